// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Step counter width; a single-step unit still needs a one-bit counter.
    function automatic int cnt_width(input int steps);
        if (steps <= 1) return 1;
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/addsub_cell.sv
// Single-bit add/subtract cell: full adder or full subtractor selected by mode.
module addsub_cell
    import addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic co
);

    always_comb begin
        s = x ^ y ^ c;
        if (mode == MODE_SUB) begin
            co = (~x & y) | (y & c) | (c & ~x);
        end else begin
            co = (x & y) | (x & c) | (y & c);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: DIGIT bits per cycle, LSB first, with
// valid/ready handshakes on both sides and carry/borrow and overflow flags.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             cbin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cbout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid is held by the sender until that edge, and ready never
    // depends combinationally on valid.

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if (WIDTH < 2) begin : g_width_chk
        $error("serial_addsub: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_chk
        $error("serial_addsub: DIGIT must divide WIDTH exactly");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d, carry_q, carry_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cbout_q, cbout_d, ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] sum_dig;
    logic [WIDTH-1:0] acc_next;
    logic             res_msb;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        addsub_cell u_cell (
            .x    (a_q[i]),
            .y    (b_q[i]),
            .c    (chain[i]),
            .mode (mode_q),
            .s    (sum_dig[i]),
            .co   (chain[i+1])
        );
    end

    // New digit enters at the MSB end; after STEPS shifts the LSB digit lands at bit 0.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    assign res_msb  = acc_next[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        cbout_d     = cbout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    mode_d     = mode;
                    carry_d    = cbin;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_next;
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = acc_next;
                    cbout_d     = chain[DIGIT];
                    // Flags use the latched operand sign bits, not the shifted copies.
                    if (mode_q == MODE_SUB) begin
                        ovf_d = (a_msb_q != b_msb_q) && (res_msb != a_msb_q);
                    end else begin
                        ovf_d = (a_msb_q == b_msb_q) && (res_msb != a_msb_q);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_ADD;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            cbout_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            cbout_q     <= cbout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cbout     = cbout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three configurations (8/1, 8/2, 16/16) against an
// arithmetic reference model, with backpressure and mid-run reset.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_in, b_in;
    logic        mode_in, cbin_in, out_ready;
    logic [2:0]  in_valid_v;
    logic [2:0]  in_ready_v, out_valid_v, cbout_v, ovf_v;
    logic [7:0]  res0, res1;
    logic [15:0] res2;
    logic [1:0]  dbg0, dbg1, dbg2;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    logic        cur_in_ready, cur_out_valid, cur_cbout, cur_ovf;
    logic [15:0] cur_result;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_in[7:0]), .b(b_in[7:0]), .mode(mode_in), .cbin(cbin_in),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .result(res0),
        .cbout(cbout_v[0]), .overflow(ovf_v[0]), .dbg_state(dbg0)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_in[7:0]), .b(b_in[7:0]), .mode(mode_in), .cbin(cbin_in),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .result(res1),
        .cbout(cbout_v[1]), .overflow(ovf_v[1]), .dbg_state(dbg1)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_in), .b(b_in), .mode(mode_in), .cbin(cbin_in),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .result(res2),
        .cbout(cbout_v[2]), .overflow(ovf_v[2]), .dbg_state(dbg2)
    );

    always_comb begin
        cur_in_ready  = in_ready_v[cur];
        cur_out_valid = out_valid_v[cur];
        cur_cbout     = cbout_v[cur];
        cur_ovf       = ovf_v[cur];
        case (cur)
            0:       cur_result = {8'h00, res0};
            1:       cur_result = {8'h00, res1};
            default: cur_result = res2;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cfg %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 2) ? 16 : 8;
    endfunction

    function automatic int steps_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer arithmetic; returns {overflow, cbout, result[15:0]}.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic md, input logic c);
        longint ua, ub, sa, sb, full, ts, mask, lim;
        logic   co, ov;
        logic [15:0] r;
        mask = (64'sd1 <<< w) - 1;
        lim  = 64'sd1 <<< (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= lim) ? ua - (64'sd1 <<< w) : ua;
        sb = (ub >= lim) ? ub - (64'sd1 <<< w) : ub;
        if (md) begin
            full = ua - ub - longint'(c);
            ts   = sa - sb - longint'(c);
            co   = (full < 0);
        end else begin
            full = ua + ub + longint'(c);
            ts   = sa + sb + longint'(c);
            co   = (full > mask);
        end
        r  = 16'(full & mask);
        ov = (ts > lim - 1) || (ts < -lim);
        return {ov, co, r};
    endfunction

    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic md, input logic c, input int hold,
                          input logic use_fixed, input logic [17:0] fixed);
        logic [17:0] exp;
        int          cyc;
        int          w;
        w   = width_of(sel);
        exp = use_fixed ? fixed : model(w, a, b, md, c);
        @(negedge clk);
        cur     = sel;
        a_in    = a;
        b_in    = b;
        mode_in = md;
        cbin_in = c;
        in_valid_v[sel] = 1'b1;
        #1;
        check("in_ready_idle", cur_in_ready, 1);
        @(posedge clk);
        #1;
        in_valid_v = '0;
        a_in    = 16'($urandom);
        b_in    = 16'($urandom);
        mode_in = ~md;
        cbin_in = ~c;
        check("in_ready_busy", cur_in_ready, 0);
        cyc = 0;
        while (!cur_out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, steps_of(sel));
        check("result", cur_result, exp[15:0]);
        check("cbout", cur_cbout, exp[16]);
        check("overflow", cur_ovf, exp[17]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", cur_out_valid, 1);
            check("hold_in_ready", cur_in_ready, 0);
            check("hold_result", {14'h0, cur_ovf, cur_cbout, cur_result}, {14'h0, exp});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", cur_out_valid, 0);
        check("in_ready_back", cur_in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid_v = '0;
        a_in       = '0;
        b_in       = '0;
        mode_in    = 1'b0;
        cbin_in    = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            check("rst_in_ready", cur_in_ready, 1);
            check("rst_out_valid", cur_out_valid, 0);
            check("rst_result", cur_result, 0);
            check("rst_flags", {cur_cbout, cur_ovf}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'h05, 16'h03, 1'b1, 1'b0, 0, 1'b1, {1'b0, 1'b0, 16'h0002});
        run_op(0, 16'h00, 16'h01, 1'b1, 1'b0, 0, 1'b1, {1'b0, 1'b1, 16'h00FF});
        run_op(0, 16'h80, 16'h01, 1'b1, 1'b0, 0, 1'b1, {1'b1, 1'b0, 16'h007F});
        run_op(1, 16'hFF, 16'h01, 1'b0, 1'b0, 0, 1'b1, {1'b0, 1'b1, 16'h0000});
        run_op(1, 16'h7F, 16'h00, 1'b0, 1'b1, 0, 1'b1, {1'b1, 1'b0, 16'h0080});
        run_op(0, 16'h3C, 16'h15, 1'b0, 1'b0, 10, 1'b1, {1'b0, 1'b0, 16'h0051});

        // Abort mid-run: reset after three of eight steps.
        @(negedge clk);
        cur     = 0;
        a_in    = 16'h55;
        b_in    = 16'h22;
        mode_in = 1'b1;
        cbin_in = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", cur_out_valid, 0);
        check("abort_in_ready", cur_in_ready, 1);
        check("abort_result", cur_result, 0);
        check("abort_flags", {cur_cbout, cur_ovf}, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_valid", cur_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 16'h10, 16'h01, 1'b1, 1'b0, 0, 1'b1, {1'b0, 1'b0, 16'h000F});

        for (int i = 0; i < 30; i++) begin
            run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'b0, '0);
        end
        for (int i = 0; i < 30; i++) begin
            run_op(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'b0, '0);
        end
        for (int i = 0; i < 200; i++) begin
            run_op(2, 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
